nios_system_sysid_checker: RTL and testbench

//  Avalon-MM read master for the system-ID slave's control port. On a start pulse it reads

---
 rtl/nios_system_sysid_checker.sv | 86 ++++++++
 tb/tb_nios_system_sysid_checker.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/nios_system_sysid_checker.sv
// nios_system_sysid_checker: Avalon-MM read master that checks the system-ID and build-timestamp words
module nios_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1581413303,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);
  typedef enum logic [2:0] {IDLE, RD_ID, WT_ID, RD_TS, WT_TS, DONE} state_t;
  localparam logic [2:0] LAT  = 3'(READ_LATENCY);
  localparam logic [7:0] TLIM = 8'(TIMEOUT_CYCLES - 1);
  state_t state, state_nxt;
  logic [7:0] tcnt;
  logic [2:0] lcnt;
  logic rd, wt, accept, expire, capture, is_id;
  always_comb begin
    rd = state == RD_ID || state == RD_TS;
    wt = state == WT_ID || state == WT_TS;
    accept = rd && !avm_waitrequest;
    expire = rd && avm_waitrequest && tcnt == TLIM;
    capture = LAT == 3'd0 ? accept : wt && lcnt == LAT;
    is_id = state == RD_ID || state == WT_ID;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? RD_ID : IDLE;
      RD_ID:   state_nxt = expire ? DONE : !accept ? RD_ID : LAT == 3'd0 ? RD_TS : WT_ID;
      WT_ID:   state_nxt = capture ? RD_TS : WT_ID;
      RD_TS:   state_nxt = expire ? DONE : !accept ? RD_TS : LAT == 3'd0 ? DONE : WT_TS;
      WT_TS:   state_nxt = capture ? DONE : WT_TS;
      default: state_nxt = IDLE;
    endcase
  end
  assign avm_read    = rd;
  assign avm_address = state == RD_TS;
  assign busy        = state != IDLE && state != DONE;
  assign done        = state == DONE;
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      tcnt     <= '0;
      lcnt     <= '0;
      id_match <= 1'b0;
      ts_match <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      state <= state_nxt;
      // stall counter restarts whenever a read phase is entered or left
      tcnt  <= (rd && state_nxt == state) ? tcnt + 8'(avm_waitrequest) : 8'd0;
      lcnt  <= accept ? 3'd1 : (wt && !capture) ? lcnt + 3'd1 : 3'd0;
      if (state == IDLE && start) begin
        id_match <= 1'b0;
        ts_match <= 1'b0;
        timeout  <= 1'b0;
        id_value <= '0;
        ts_value <= '0;
      end
      if (capture && is_id) id_value <= avm_readdata;
      if (capture && !is_id) begin
        ts_value <= avm_readdata;
        id_match <= id_value == EXPECTED_ID;
        ts_match <= avm_readdata == EXPECTED_TS;
      end
      if (expire) begin
        timeout  <= 1'b1;
        id_match <= 1'b0;
        ts_match <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// tb_nios_system_sysid_checker: directed vectors plus corner sequences for the sysid checker
module tb_nios_system_sysid_checker;
  localparam logic [31:0] EXP_TS = 32'd1581413303;
  logic clock, reset, start, start2;
  logic busy, done, id_match, ts_match, timeout, avm_address, avm_read, wr0;
  logic [31:0] id_value, ts_value, readdata0;
  logic busy2, done2, id_match2, ts_match2, timeout2, avm_address2, avm_read2;
  logic [31:0] id_value2, ts_value2, readdata2;
  logic [31:0] id_data, ts_data;
  logic stuck;
  int wait_n;
  logic [8:0] scnt = '0;
  logic [1:0] acc2 = '0, ad2 = '0;
  int total = 0, bad = 0;

  typedef struct {
    logic [31:0] id, ts;
    int          w, lat;
    logic        idm, tsm;
  } vec_t;
  vec_t v[6];

  nios_system_sysid_checker u0 (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .id_match(id_match), .ts_match(ts_match), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value), .avm_address(avm_address),
    .avm_read(avm_read), .avm_waitrequest(wr0), .avm_readdata(readdata0));

  nios_system_sysid_checker #(.READ_LATENCY(2)) u2 (
    .clock(clock), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .id_match(id_match2), .ts_match(ts_match2), .timeout(timeout2),
    .id_value(id_value2), .ts_value(ts_value2), .avm_address(avm_address2),
    .avm_read(avm_read2), .avm_waitrequest(1'b0), .avm_readdata(readdata2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // zero-latency slave: stalls the first wait_n cycles of every read
  assign wr0 = stuck || (avm_read && int'(scnt) < wait_n);
  assign readdata0 = avm_address ? ts_data : id_data;
  always @(posedge clock) scnt <= (avm_read && wr0) ? scnt + 9'd1 : 9'd0;

  // two-cycle-latency slave: data valid only in the cycle two after accept
  always @(posedge clock) begin
    acc2 <= {acc2[0], avm_read2};
    ad2  <= {ad2[0], avm_address2};
  end
  assign readdata2 = acc2[1] ? (ad2[1] ? ts_data : id_data) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run0(output int lat, output int n0, output int n1, output int busy_bad);
    lat = -1; n0 = 0; n1 = 0; busy_bad = 0;
    @(negedge clock) start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (avm_read) begin
        if (avm_address) n1++;
        else n0++;
      end
      if (done) begin
        lat = c;
        break;
      end
      if (!busy) busy_bad++;
      @(posedge clock); #1;
    end
    if (lat > 0 && busy) busy_bad++;
    @(posedge clock); #1;
    if (done) busy_bad++;
  endtask

  initial begin
    int lat, n0, n1, bb, extra;
    v[0] = '{32'd0,          EXP_TS,        0, 3,  1'b1, 1'b1};
    v[1] = '{32'd0,          32'h5E42_0000, 0, 3,  1'b1, 1'b0};
    v[2] = '{32'd0,          EXP_TS,        4, 11, 1'b1, 1'b1};
    v[3] = '{32'h0000_1234,  EXP_TS,        0, 3,  1'b0, 1'b1};
    v[4] = '{32'd0,          EXP_TS,        1, 5,  1'b1, 1'b1};
    v[5] = '{32'hFFFF_FFFF,  32'd0,         2, 7,  1'b0, 1'b0};
    reset = 1'b1; start = 1'b0; start2 = 1'b0; stuck = 1'b0; wait_n = 0;
    id_data = '0; ts_data = EXP_TS;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_read", 32'(avm_read), 0);
    chk("rst_addr", 32'(avm_address), 0);
    chk("rst_flags", {29'd0, id_match, ts_match, timeout}, 0);
    chk("rst_id_value", id_value, 0);
    chk("rst_ts_value", ts_value, 0);
    chk("rst_busy2", 32'(busy2), 0);
    @(negedge clock) reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      id_data = v[i].id; ts_data = v[i].ts; wait_n = v[i].w;
      run0(lat, n0, n1, bb);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v[i].lat));
      chk($sformatf("v%0d_rd_addr0", i), 32'(n0), 32'(1 + v[i].w));
      chk($sformatf("v%0d_rd_addr1", i), 32'(n1), 32'(1 + v[i].w));
      chk($sformatf("v%0d_busy_done", i), 32'(bb), 0);
      chk($sformatf("v%0d_id_match", i), 32'(id_match), 32'(v[i].idm));
      chk($sformatf("v%0d_ts_match", i), 32'(ts_match), 32'(v[i].tsm));
      chk($sformatf("v%0d_timeout", i), 32'(timeout), 0);
      chk($sformatf("v%0d_id_value", i), id_value, v[i].id);
      chk($sformatf("v%0d_ts_value", i), ts_value, v[i].ts);
    end

    // waitrequest stuck high: first read times out, second read skipped
    stuck = 1'b1; wait_n = 0; id_data = 32'd0; ts_data = EXP_TS;
    run0(lat, n0, n1, bb);
    chk("to_latency", 32'(lat), 256);
    chk("to_rd_addr0", 32'(n0), 255);
    chk("to_rd_addr1", 32'(n1), 0);
    chk("to_busy_done", 32'(bb), 0);
    chk("to_timeout", 32'(timeout), 1);
    chk("to_id_match", 32'(id_match), 0);
    chk("to_ts_match", 32'(ts_match), 0);
    chk("to_id_value", id_value, 0);
    chk("to_read_after", 32'(avm_read), 0);
    stuck = 1'b0;

    // READ_LATENCY=2 instance
    id_data = 32'd0; ts_data = EXP_TS; lat = -1;
    @(negedge clock) start2 = 1'b1;
    @(posedge clock); #1 start2 = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      if (done2) begin
        lat = c;
        break;
      end
      @(posedge clock); #1;
    end
    chk("lat2_latency", 32'(lat), 7);
    chk("lat2_id_value", id_value2, 32'd0);
    chk("lat2_ts_value", ts_value2, EXP_TS);
    chk("lat2_matches", {30'd0, id_match2, ts_match2}, 32'd3);
    chk("lat2_timeout", 32'(timeout2), 0);

    // reset while reading the timestamp
    id_data = 32'h1234_5678; ts_data = EXP_TS; wait_n = 0;
    @(negedge clock) start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    @(posedge clock); #1;
    chk("mid_rd_ts", {30'd0, avm_read, avm_address}, 32'd3);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("mid_read", 32'(avm_read), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_id_value", id_value, 0);
    reset = 1'b0;
    id_data = 32'd0;
    run0(lat, n0, n1, bb);
    chk("post_rst_latency", 32'(lat), 3);
    chk("post_rst_matches", {30'd0, id_match, ts_match}, 32'd3);

    // start held high through busy and DONE cycles must not launch a second run
    @(negedge clock) start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    @(negedge clock) start = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("busy_start_done", 32'(done), 1);
    @(posedge clock); #1 start = 1'b0;
    extra = 0;
    repeat (10) begin
      if (busy || avm_read) extra++;
      @(posedge clock); #1;
    end
    chk("busy_start_ignored", 32'(extra), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
